// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I core front end: fetch FSM states and the
// reservation-buffer entry layout.
package rv32i_pkg;

  localparam int          RV_XLEN = 32;
  localparam logic [31:0] RV_NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [31:0]        instr;
    logic               filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_rsv_buf.sv
// Fetch reservation buffer: entries are allocated in issue order, filled in
// response order and popped from the head; clear frees every entry at once.
module fetch_rsv_buf
  import rv32i_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               alloc_i,
  input  logic [RV_XLEN-1:0] alloc_pc_i,
  input  logic               fill_i,
  input  logic [31:0]        fill_instr_i,
  input  logic               pop_i,
  output logic [RV_XLEN-1:0] head_pc_o,
  output logic [31:0]        head_instr_o,
  output logic               head_valid_o,
  output logic [CW-1:0]      count_o,
  output logic [CW-1:0]      unfilled_o
);

  fetch_entry_t  ent_q [DEPTH];
  logic [PW-1:0] head_q, tail_q, fill_q;
  logic [CW-1:0] count_q, unfilled_q;

  // Responses return in order, so the oldest unfilled entry is tracked by its
  // own pointer rather than searched for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '{pc: '0, instr: RV_NOP, filled: 1'b0};
      end
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else if (clear_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      if (alloc_i) begin
        ent_q[tail_q].pc     <= alloc_pc_i;
        ent_q[tail_q].filled <= 1'b0;
        tail_q               <= tail_q + 1'b1;
      end
      if (fill_i) begin
        ent_q[fill_q].instr  <= fill_instr_i;
        ent_q[fill_q].filled <= 1'b1;
        fill_q               <= fill_q + 1'b1;
      end
      if (pop_i) begin
        head_q <= head_q + 1'b1;
      end
      count_q    <= count_q + CW'(alloc_i) - CW'(pop_i);
      unfilled_q <= unfilled_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  assign head_pc_o    = ent_q[head_q].pc;
  assign head_instr_o = ent_q[head_q].instr;
  assign head_valid_o = (count_q != '0) && ent_q[head_q].filled;
  assign count_o      = count_q;
  assign unfilled_o   = unfilled_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage of the RV32I core: owns the PC, pipelines word fetches and feeds IF/ID.
// Optional FETCH_PERF_EN adds pop and stall-cycle counters.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter int             XLEN     = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int             DEPTH    = 2,
  localparam int            CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
  output logic            if_valid_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_stall_o
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   kill_q, kill_d;

  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;
  logic            head_valid;
  logic [CW-1:0]   buf_count, buf_unfilled;
  logic            pop, issue, fill;

  // Handshake: IF/ID takes the head when if_valid_o && !stall_i; imem accepts
  // every request and answers in order, one imem_rvalid_i per request.
  assign pop   = head_valid && !stall_i && !redirect_i;
  assign issue = (state_q == FETCH) && !redirect_i && ((buf_count - CW'(pop)) < CW'(DEPTH));
  assign fill  = imem_rvalid_i && (state_q == FETCH) && !redirect_i;

  fetch_rsv_buf #(.DEPTH(DEPTH)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (redirect_i),
    .alloc_i      (issue),
    .alloc_pc_i   (pc_q),
    .fill_i       (fill),
    .fill_instr_i (imem_rdata_i),
    .pop_i        (pop),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .head_valid_o (head_valid),
    .count_o      (buf_count),
    .unfilled_o   (buf_unfilled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      kill_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  // kill_cnt counts responses still owed for fetches a redirect threw away.
  always_comb begin
    kill_d  = kill_q;
    state_d = state_q;
    pc_d    = pc_q;
    if (state_q == DRAIN) begin
      kill_d = kill_q - CW'(imem_rvalid_i);
    end else if (redirect_i) begin
      kill_d = buf_unfilled - CW'(imem_rvalid_i);
    end
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (issue) begin
      pc_d = pc_q + XLEN'(4);
    end
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (redirect_i && (kill_d != '0)) state_d = DRAIN;
      DRAIN:   if (kill_d == '0) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req_o  = issue;
    imem_addr_o = pc_q;
    if_valid_o  = head_valid;
    if_pc_o     = head_valid ? head_pc : '0;
    if_instr_o  = head_valid ? head_instr : RV_NOP;
  end

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> ((state_q == DRAIN) ? (kill_q != '0) : (buf_unfilled != '0)));

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall_i && head_valid) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule
